// File: rtl/pll_seq_pkg.sv
// Shared constants for the rPLL lock sequencer: FSM state codes, deglitch
// length and the sizing helper for the single sequencing counter.
package pll_seq_pkg;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABILIZE = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  localparam int DEGLITCH_CYC = 8;

  // Wide enough to hold the largest compare value with one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// Generic N-stage single-bit synchronizer, async active-high reset to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer: timed PLL reset, lock wait with bounded retries,
// lock stability qualification. Optional RUN dropout filter: PLL_LOCK_DEGLITCH_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 270000,
  parameter int MAX_RETRIES      = 3,
  parameter int SYNC_STAGES      = 2
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       rst_out,
  output logic       locked,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam int CW = cnt_width(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRIES);

  logic          lock_s;
  logic          lock_lost;
  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    retry_nxt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clkin),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

`ifdef PLL_LOCK_DEGLITCH_EN
  // Loss is declared on the eighth consecutive low lock_s seen in RUN.
  logic [2:0] loss_cnt;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst)                                       loss_cnt <= '0;
    else if (state != ST_RUN || lock_s || restart) loss_cnt <= '0;
    else if (loss_cnt != 3'(DEGLITCH_CYC - 1))     loss_cnt <= loss_cnt + 3'd1;
  end

  assign lock_lost = !lock_s && (loss_cnt == 3'(DEGLITCH_CYC - 1));
`else
  assign lock_lost = !lock_s;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;

    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = ST_STABILIZE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_LIMIT) begin
            state_nxt = ST_FAIL;
          end else begin
            retry_nxt = retry_cnt + 2'd1;
            state_nxt = ST_PLL_RST;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_STABILIZE: begin
        // A dropout here restarts qualification; it is not a timeout.
        if (!lock_s)                 cnt_nxt   = '0;
        else if (cnt == STABLE_LAST) state_nxt = ST_RUN;
        else                         cnt_nxt   = cnt + 1'b1;
      end
      ST_RUN: begin
        if (lock_lost) state_nxt = ST_PLL_RST;
      end
      ST_FAIL: ;
      default: state_nxt = ST_PLL_RST;
    endcase

    if (restart) begin
      state_nxt = ST_PLL_RST;
      retry_nxt = '0;
    end

    // Counter restarts on every state entry, including a restart while in PLL_RST.
    if (state_nxt != state || restart) cnt_nxt = '0;
    if (state_nxt == ST_RUN)           retry_nxt = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      // NOTE: every flop, outputs included, takes its documented value on rst.
      state     <= ST_PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      rst_out   <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_reset <= (state_nxt == ST_PLL_RST);
      rst_out   <= (state_nxt != ST_RUN);
      locked    <= (state_nxt == ST_RUN);
      fail      <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed/randomized bench for pll_lock_sequencer; expected timings are derived
// from the sequencing rules (pulse, sync latency, stability and timeout windows).
module tb_pll_lock_sequencer;

  localparam int RST_PULSE = 16;
  localparam int STABLE    = 1024;
  localparam int TIMEOUT   = 400;
  localparam int RETRIES   = 3;
  localparam int SYNC      = 2;
`ifdef PLL_LOCK_DEGLITCH_EN
  localparam int DROP_LOSS = 8;
`else
  localparam int DROP_LOSS = 1;
`endif

  localparam int SEL_PLLRST = 0;
  localparam int SEL_RSTOUT = 1;
  localparam int SEL_FAIL   = 2;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, rst_out, locked, fail;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;
  int n;
  int d;
  int bad;

  always #5 clkin = ~clkin;

  pll_lock_sequencer #(
    .RST_PULSE_CYC    (RST_PULSE),
    .LOCK_STABLE_CYC  (STABLE),
    .LOCK_TIMEOUT_CYC (TIMEOUT),
    .MAX_RETRIES      (RETRIES),
    .SYNC_STAGES      (SYNC)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .rst_out   (rst_out),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SEL_PLLRST: return pll_reset;
      SEL_RSTOUT: return rst_out;
      default:    return fail;
    endcase
  endfunction

  // Counts clock edges until the selected output leaves 'val' (bounded).
  task automatic measure(input int sel, input logic val, input int bound, output int cycles);
    cycles = 0;
    while (sig(sel) === val && cycles < bound) begin
      @(negedge clkin);
      cycles++;
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clkin);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clkin);
    restart = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_pll_reset", pll_reset, 1);
    check("rst_rst_out", rst_out, 1);
    check("rst_locked", locked, 0);
    check("rst_fail", fail, 0);
    check("rst_retry_cnt", retry_cnt, 0);
    rst = 1'b0;

    // Nominal bring-up, lock 100 cycles after reset release
    measure(SEL_PLLRST, 1'b1, 100, n);
    check("first_pulse_width", n, RST_PULSE);
    tick(100 - RST_PULSE);
    pll_lock = 1'b1;
    measure(SEL_RSTOUT, 1'b1, 3000, n);
    check("lock_to_release", n, SYNC + 1 + STABLE);
    check("run_locked", locked, 1);
    check("run_retry_cnt", retry_cnt, 0);
    check("run_pll_reset", pll_reset, 0);

`ifdef PLL_LOCK_DEGLITCH_EN
    // Dropouts shorter than the filter length are ignored
    d = $urandom_range(1, DROP_LOSS - 1);
    pll_lock = 1'b0;
    bad = 0;
    for (int i = 1; i <= d + SYNC + 4; i++) begin
      @(negedge clkin);
      if (i == d) pll_lock = 1'b1;
      if (rst_out !== 1'b0 || locked !== 1'b1) bad++;
    end
    check("short_dropout_ignored", bad, 0);
`endif

    // Lock loss in RUN re-sequences
    tick($urandom_range(1, 50));
    pll_lock = 1'b0;
    n = 0;
    while (rst_out === 1'b0 && n < 100) begin
      @(negedge clkin);
      n++;
      if (n == DROP_LOSS) pll_lock = 1'b1;
    end
    pll_lock = 1'b1;
    check("loss_latency", n, SYNC + DROP_LOSS);
    check("loss_pll_reset", pll_reset, 1);
    check("loss_locked", locked, 0);
    measure(SEL_PLLRST, 1'b1, 100, n);
    check("reseq_pulse_width", n, RST_PULSE);
    measure(SEL_RSTOUT, 1'b1, 3000, n);
    check("reseq_release", n, STABLE + 1);

    // Restart from RUN, then a one-cycle dropout at stability count 500
    pulse_restart();
    check("restart_run_rst_out", rst_out, 1);
    check("restart_run_pll_reset", pll_reset, 1);
    measure(SEL_PLLRST, 1'b1, 100, n);
    check("restart_pulse_width", n, RST_PULSE);
    tick(501);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    measure(SEL_RSTOUT, 1'b1, 3000, n);
    check("stab_glitch_release", n, SYNC + STABLE);
    check("stab_glitch_retry_cnt", retry_cnt, 0);

    // Lock never arrives: four timeouts then FAIL
    pll_lock = 1'b0;
    pulse_restart();
    for (int i = 0; i <= RETRIES; i++) begin
      measure(SEL_PLLRST, 1'b1, 100, n);
      check("retry_pulse_width", n, RST_PULSE);
      if (i < RETRIES) begin
        measure(SEL_PLLRST, 1'b0, TIMEOUT + 50, n);
        check("timeout_len", n, TIMEOUT);
        check("retry_cnt_step", retry_cnt, i + 1);
      end else begin
        measure(SEL_FAIL, 1'b0, TIMEOUT + 50, n);
        check("fail_timeout_len", n, TIMEOUT);
      end
    end
    check("fail_flag", fail, 1);
    check("fail_rst_out", rst_out, 1);
    check("fail_pll_reset", pll_reset, 0);
    check("fail_locked", locked, 0);
    check("fail_retry_cnt", retry_cnt, RETRIES);
    tick(50);
    check("fail_sticky", fail, 1);
    pulse_restart();
    check("restart_fail_clear", fail, 0);
    check("restart_fail_retry", retry_cnt, 0);
    check("restart_fail_pll_reset", pll_reset, 1);

    // Restart coincident with the final timeout wins
    for (int i = 0; i <= RETRIES; i++) begin
      measure(SEL_PLLRST, 1'b1, 100, n);
      if (i < RETRIES) measure(SEL_PLLRST, 1'b0, TIMEOUT + 50, n);
    end
    tick(TIMEOUT - 1);
    pulse_restart();
    check("race_no_fail", fail, 0);
    check("race_retry_cnt", retry_cnt, 0);
    check("race_pll_reset", pll_reset, 1);
    measure(SEL_PLLRST, 1'b1, 100, n);
    check("race_pulse_width", n, RST_PULSE);

    // Async reset mid-STABILIZE, between clock edges
    pll_lock = 1'b1;
    tick(SYNC + 1 + 200);
    check("stab_pre_pll_reset", pll_reset, 0);
    @(posedge clkin);
    #2;
    rst = 1'b1;
    #1;
    check("async_stab_pll_reset", pll_reset, 1);
    check("async_stab_rst_out", rst_out, 1);
    check("async_stab_locked", locked, 0);
    @(negedge clkin);
    pll_lock = 1'b0;
    rst = 1'b0;

    // Randomized lock arrival times (restart issued while in PLL_RST)
    for (int k = 0; k < 2; k++) begin
      tick($urandom_range(0, 10));
      pll_lock = 1'b0;
      pulse_restart();
      measure(SEL_PLLRST, 1'b1, 100, n);
      check("rand_pulse_width", n, RST_PULSE);
      d = $urandom_range(0, 300);
      tick(d);
      pll_lock = 1'b1;
      measure(SEL_RSTOUT, 1'b1, 3000, n);
      check("rand_lock_to_release", n, SYNC + 1 + STABLE);
      check("rand_locked", locked, 1);
    end

    // Async reset in RUN
    @(posedge clkin);
    #3;
    rst = 1'b1;
    #1;
    check("async_run_locked", locked, 0);
    check("async_run_rst_out", rst_out, 1);
    check("async_run_pll_reset", pll_reset, 1);
    check("async_run_fail", fail, 0);
    @(negedge clkin);
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
